// File: rtl/phi_copy_sequencer.sv
// Phi copy sequencer: turns a parallel copy group into an ordered list of
// register moves, breaking copy cycles through TMP_REG.
// Optional feature macro: PHI_COPY_STATS_EN (move / cycle-break counters).
module phi_copy_sequencer #(
  parameter int unsigned     REG_W   = 8,
  parameter int unsigned     DEPTH   = 8,
  parameter logic [REG_W-1:0] TMP_REG = {REG_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] in_dst,
  input  logic [REG_W-1:0] in_src,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_dst,
  output logic [REG_W-1:0] out_src,
  output logic             out_last,
  output logic             grp_done,
  output logic             err_overflow,
  output logic             err_dup,
  output logic [15:0]      stat_moves,
  output logic [15:0]      stat_breaks
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_LOAD, S_RESOLVE, S_DONE} state_t;

  state_t             state;
  logic [DEPTH-1:0]   tbl_vld;
  logic [REG_W-1:0]   tbl_dst [DEPTH];
  logic [REG_W-1:0]   tbl_src [DEPTH];
  logic [IDX_W-1:0]   out_idx;

  logic [DEPTH-1:0]   n_vld;
  logic [REG_W-1:0]   n_dst [DEPTH];
  logic [REG_W-1:0]   n_src [DEPTH];
  logic               acc, hs, is_break, is_self, dup_hit, set_dup, set_ovf, wr;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;

  logic [DEPTH-1:0]   rdy;
  logic [CNT_W-1:0]   pend_cnt;
  logic               rdy_found, any_pend;
  logic [IDX_W-1:0]   rdy_idx, pend_idx, sel_idx;
  logic [REG_W-1:0]   sel_dst, sel_src;
  logic               sel_last;

  // Next table contents: pair insertion in LOAD, entry retire / src rewrite on a move handshake
  always_comb begin
    n_vld      = tbl_vld;
    n_dst      = tbl_dst;
    n_src      = tbl_src;
    acc        = in_valid && in_ready;
    hs         = (state == S_RESOLVE) && out_valid && out_ready;
    is_break   = (out_dst == TMP_REG);
    is_self    = (in_dst == in_src);
    dup_hit    = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (tbl_vld[i] && (tbl_dst[i] == in_dst)) dup_hit = 1'b1;
      if (!tbl_vld[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    set_dup = acc && !is_self && (dup_hit || (in_dst == TMP_REG) || (in_src == TMP_REG));
    set_ovf = acc && !is_self && !set_dup && !free_found;
    wr      = acc && !is_self && !set_dup && free_found;
    if (wr) begin
      n_vld[free_idx] = 1'b1;
      n_dst[free_idx] = in_dst;
      n_src[free_idx] = in_src;
    end
    if (hs) begin
      if (is_break) begin
        for (int i = 0; i < int'(DEPTH); i++)
          if (tbl_vld[i] && (tbl_src[i] == out_src)) n_src[i] = TMP_REG;
      end else begin
        n_vld[out_idx] = 1'b0;
      end
    end
  end

  // Pick the next move from the next-table: lowest READY entry, else break the lowest pending
  always_comb begin
    rdy       = '0;
    pend_cnt  = '0;
    rdy_found = 1'b0;
    rdy_idx   = '0;
    pend_idx  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (n_vld[i]) begin
        pend_cnt = pend_cnt + CNT_W'(1);
        rdy[i]   = 1'b1;
        for (int j = 0; j < int'(DEPTH); j++)
          if ((j != i) && n_vld[j] && (n_src[j] == n_dst[i])) rdy[i] = 1'b0;
      end
    end
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        rdy_found = 1'b1;
        rdy_idx   = IDX_W'(i);
      end
      if (n_vld[i]) pend_idx = IDX_W'(i);
    end
    any_pend = |n_vld;
    if (rdy_found) begin
      sel_dst = n_dst[rdy_idx];
      sel_src = n_src[rdy_idx];
      sel_idx = rdy_idx;
    end else begin
      sel_dst = TMP_REG;
      sel_src = n_dst[pend_idx];
      sel_idx = pend_idx;
    end
    sel_last = rdy_found && (pend_cnt == CNT_W'(1));
  end

  // Control FSM with registered outputs and the pending table
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_LOAD;
      tbl_vld      <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_dst      <= '0;
      out_src      <= '0;
      out_idx      <= '0;
      grp_done     <= 1'b0;
      err_overflow <= 1'b0;
      err_dup      <= 1'b0;
    end else begin
      tbl_vld      <= n_vld;
      tbl_dst      <= n_dst;
      tbl_src      <= n_src;
      grp_done     <= 1'b0;
      err_overflow <= err_overflow | set_ovf;
      err_dup      <= err_dup | set_dup;
      case (state)
        S_LOAD: begin
          if (acc && in_last) begin
            in_ready <= 1'b0;
            if (any_pend) begin
              state     <= S_RESOLVE;
              out_valid <= 1'b1;
              out_dst   <= sel_dst;
              out_src   <= sel_src;
              out_last  <= sel_last;
              out_idx   <= sel_idx;
            end else begin
              state    <= S_DONE;
              grp_done <= 1'b1;
            end
          end
        end
        S_RESOLVE: begin
          if (hs) begin
            if (any_pend) begin
              out_dst  <= sel_dst;
              out_src  <= sel_src;
              out_last <= sel_last;
              out_idx  <= sel_idx;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              grp_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state    <= S_LOAD;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= S_LOAD;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef PHI_COPY_STATS_EN
  // Wrapping counters of emitted moves and cycle breaks
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_moves  <= '0;
      stat_breaks <= '0;
    end else if (hs) begin
      stat_moves <= stat_moves + 16'd1;
      if (is_break) stat_breaks <= stat_breaks + 16'd1;
    end
  end
`else
  assign stat_moves  = 16'd0;
  assign stat_breaks = 16'd0;
`endif

endmodule
